// File: rtl/mult_matrices_pkg.sv
// mult_matrices_pkg
//   Definitions shared by the 4x4 complex matrix multiplier blocks:
//   - DefaultWidth : signed width of one real/imaginary component
//   - accWidthOf() : accumulator width. Four complex products fit in 2*Width+3 bits.
//   - state_t and ST_* : FSM encoding of the row MAC stage
//   - colIdx_t     : 2-bit column/element index, also used for the column mux SEL
package mult_matrices_pkg;

  localparam int DefaultWidth = 8;

  function automatic int accWidthOf(input int width);
    return 2 * width + 3;
  endfunction

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MAC  = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

  typedef logic [1:0] colIdx_t;

endpackage

// File: rtl/complex_mult.sv
// complex_mult
//   Purely combinational signed complex multiply (a * b).
//   Ports:
//     i_aReal, i_aImag : signed Width-bit operand a
//     i_bReal, i_bImag : signed Width-bit operand b
//     o_pReal, o_pImag : signed (2*Width+1)-bit product, full precision
module complex_mult #(
  parameter int Width = 8
) (
  input  logic signed [Width-1:0]   i_aReal,
  input  logic signed [Width-1:0]   i_aImag,
  input  logic signed [Width-1:0]   i_bReal,
  input  logic signed [Width-1:0]   i_bImag,
  output logic signed [2*Width:0]   o_pReal,
  output logic signed [2*Width:0]   o_pImag
);

  localparam int ProdWidth = 2 * Width + 1;

  logic signed [2*Width-1:0] w_rr;
  logic signed [2*Width-1:0] w_ii;
  logic signed [2*Width-1:0] w_ri;
  logic signed [2*Width-1:0] w_ir;

  assign w_rr = i_aReal * i_bReal;
  assign w_ii = i_aImag * i_bImag;
  assign w_ri = i_aReal * i_bImag;
  assign w_ir = i_aImag * i_bReal;

  // One extra bit absorbs the worst case (-2^(W-1))^2 + (-2^(W-1))^2.
  assign o_pReal = ProdWidth'(w_rr) - ProdWidth'(w_ii);
  assign o_pImag = ProdWidth'(w_ri) + ProdWidth'(w_ir);

endmodule

// File: rtl/fila_por_columna_mac.sv
// fila_por_columna_mac
//   Row-by-column complex MAC stage. It latches one row of A and walks the
//   column mux through SEL = 0..3. For each column it accumulates
//   A(k)*B(k,SEL) over k = 0..3 and presents C(SEL) on a valid/ready port.
//   Ports:
//     CLK, RST_N           : clock, asynchronous active-low reset
//     Start                : begin a row (only looked at while idle)
//     RowA{1..4}{Real,Imag}: row of A, latched on an accepted Start
//     Col{1..4}{Real,Imag} : column mux outputs for the current SEL
//     SEL                  : column index driven to the mux
//     ResReal/ResImag      : result C(ResIdx), valid while ResValid
//     ResIdx, ResValid     : result index / valid
//     ResReady             : consumer accepts result
//     Busy, Done           : row in progress / one-cycle end-of-row pulse
//   Build option:
//     MULT_REG_EN : a register stage between the multiplier and the accumulator
//                   (MAC phase grows to 4 issue cycles + 1 drain cycle)
module fila_por_columna_mac
  import mult_matrices_pkg::*;
#(
  parameter int Width    = DefaultWidth,
  parameter int AccWidth = accWidthOf(Width)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       Start,
  input  logic signed [Width-1:0]    RowA1Real,
  input  logic signed [Width-1:0]    RowA1Imag,
  input  logic signed [Width-1:0]    RowA2Real,
  input  logic signed [Width-1:0]    RowA2Imag,
  input  logic signed [Width-1:0]    RowA3Real,
  input  logic signed [Width-1:0]    RowA3Imag,
  input  logic signed [Width-1:0]    RowA4Real,
  input  logic signed [Width-1:0]    RowA4Imag,
  input  logic signed [Width-1:0]    Col1Real,
  input  logic signed [Width-1:0]    Col1Imag,
  input  logic signed [Width-1:0]    Col2Real,
  input  logic signed [Width-1:0]    Col2Imag,
  input  logic signed [Width-1:0]    Col3Real,
  input  logic signed [Width-1:0]    Col3Imag,
  input  logic signed [Width-1:0]    Col4Real,
  input  logic signed [Width-1:0]    Col4Imag,
  output colIdx_t                    SEL,
  output logic signed [AccWidth-1:0] ResReal,
  output logic signed [AccWidth-1:0] ResImag,
  output colIdx_t                    ResIdx,
  output logic                       ResValid,
  input  logic                       ResReady,
  output logic                       Busy,
  output logic                       Done
);

  localparam int ProdWidth = 2 * Width + 1;

`ifdef MULT_REG_EN
  localparam logic [2:0] KLast = 3'd4;
`else
  localparam logic [2:0] KLast = 3'd3;
`endif

  state_t                    r_state;
  logic [2:0]                r_k;
  colIdx_t                   r_sel;
  logic                      r_resValid;
  logic                      r_busy;
  logic                      r_done;
  logic signed [AccWidth-1:0] r_accReal;
  logic signed [AccWidth-1:0] r_accImag;
  logic signed [Width-1:0]   r_aReal [4];
  logic signed [Width-1:0]   r_aImag [4];

  logic signed [Width-1:0]   w_colReal [4];
  logic signed [Width-1:0]   w_colImag [4];
  logic signed [Width-1:0]   w_opAReal;
  logic signed [Width-1:0]   w_opAImag;
  logic signed [Width-1:0]   w_opBReal;
  logic signed [Width-1:0]   w_opBImag;
  logic signed [ProdWidth-1:0] w_prodReal;
  logic signed [ProdWidth-1:0] w_prodImag;
  logic signed [AccWidth-1:0]  w_addReal;
  logic signed [AccWidth-1:0]  w_addImag;

  assign w_colReal[0] = Col1Real;
  assign w_colImag[0] = Col1Imag;
  assign w_colReal[1] = Col2Real;
  assign w_colImag[1] = Col2Imag;
  assign w_colReal[2] = Col3Real;
  assign w_colImag[2] = Col3Imag;
  assign w_colReal[3] = Col4Real;
  assign w_colImag[3] = Col4Imag;

  // k picks both A(k) and column mux output k. In the drain cycle (k=4) the
  // index wraps to 0, but nothing is issued then.
  assign w_opAReal = r_aReal[r_k[1:0]];
  assign w_opAImag = r_aImag[r_k[1:0]];
  assign w_opBReal = w_colReal[r_k[1:0]];
  assign w_opBImag = w_colImag[r_k[1:0]];

  complex_mult #(
    .Width (Width)
  ) u_complexMult (
    .i_aReal (w_opAReal),
    .i_aImag (w_opAImag),
    .i_bReal (w_opBReal),
    .i_bImag (w_opBImag),
    .o_pReal (w_prodReal),
    .o_pImag (w_prodImag)
  );

`ifdef MULT_REG_EN
  logic signed [ProdWidth-1:0] r_pipeReal;
  logic signed [ProdWidth-1:0] r_pipeImag;
  logic                        r_pipeValid;

  assign w_addReal = {{(AccWidth-ProdWidth){r_pipeReal[ProdWidth-1]}}, r_pipeReal};
  assign w_addImag = {{(AccWidth-ProdWidth){r_pipeImag[ProdWidth-1]}}, r_pipeImag};
`else
  assign w_addReal = {{(AccWidth-ProdWidth){w_prodReal[ProdWidth-1]}}, w_prodReal};
  assign w_addImag = {{(AccWidth-ProdWidth){w_prodImag[ProdWidth-1]}}, w_prodImag};
`endif

  // SEL only moves when leaving OUT, so the mux output has a full cycle to
  // settle before its first MAC use.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_sel      <= '0;
      r_resValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_accReal  <= '0;
      r_accImag  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_aReal[i] <= '0;
        r_aImag[i] <= '0;
      end
`ifdef MULT_REG_EN
      r_pipeReal  <= '0;
      r_pipeImag  <= '0;
      r_pipeValid <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_aReal[0] <= RowA1Real;
            r_aImag[0] <= RowA1Imag;
            r_aReal[1] <= RowA2Real;
            r_aImag[1] <= RowA2Imag;
            r_aReal[2] <= RowA3Real;
            r_aImag[2] <= RowA3Imag;
            r_aReal[3] <= RowA4Real;
            r_aImag[3] <= RowA4Imag;
            r_sel     <= '0;
            r_accReal <= '0;
            r_accImag <= '0;
            r_k       <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_MAC;
`ifdef MULT_REG_EN
            r_pipeReal  <= '0;
            r_pipeImag  <= '0;
            r_pipeValid <= 1'b0;
`endif
          end
        end

        ST_MAC: begin
`ifdef MULT_REG_EN
          // Issue while k<4, then one drain cycle. The accumulator trails
          // the issue stream by one cycle.
          if (r_k != KLast) begin
            r_pipeReal  <= w_prodReal;
            r_pipeImag  <= w_prodImag;
            r_pipeValid <= 1'b1;
          end else begin
            r_pipeValid <= 1'b0;
          end
          if (r_pipeValid) begin
            r_accReal <= r_accReal + w_addReal;
            r_accImag <= r_accImag + w_addImag;
          end
`else
          r_accReal <= r_accReal + w_addReal;
          r_accImag <= r_accImag + w_addImag;
`endif
          if (r_k == KLast) begin
            r_k        <= '0;
            r_resValid <= 1'b1;
            r_state    <= ST_OUT;
          end else begin
            r_k <= r_k + 3'd1;
          end
        end

        ST_OUT: begin
          if (ResReady) begin
            r_resValid <= 1'b0;
            if (r_sel == 2'd3) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_sel     <= r_sel + 2'd1;
              r_accReal <= '0;
              r_accImag <= '0;
              r_k       <= '0;
              r_state   <= ST_MAC;
`ifdef MULT_REG_EN
              r_pipeReal  <= '0;
              r_pipeImag  <= '0;
              r_pipeValid <= 1'b0;
`endif
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The accumulator itself is the result register. It is stable for the
  // whole OUT phase, including backpressure.
  assign SEL      = r_sel;
  assign ResIdx   = r_sel;
  assign ResReal  = r_accReal;
  assign ResImag  = r_accImag;
  assign ResValid = r_resValid;
  assign Busy     = r_busy;
  assign Done     = r_done;

endmodule
